// File: rtl/design1_bist_engine.sv
// design1_bist_engine
//   Built-in self-test driver/checker for the combinational design1 netlist
//   (14 inputs, 8 outputs). A Galois LFSR supplies stimulus vectors, a Galois
//   MISR compacts the netlist responses, and the final signature is compared
//   against GOLDEN_SIG.
//
//   Optional feature macro: BIST_SETTLE_EN
//     defined   - each pattern takes two cycles (RUN drives, SETTLE captures).
//     undefined - single-cycle capture, SETTLE state not built.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active-high
//   start      in   1        begin a run (pulse or level)
//   stim       out  VEC_W    vector to netlist inputs (registered LFSR state)
//   rsp        in   RSP_W    netlist outputs
//   busy       out  1        run in progress
//   done       out  1        run finished; held until next start or reset
//   pass       out  1        final signature == GOLDEN_SIG; valid while done=1
//   signature  out  RSP_W    final MISR value; valid while done=1
//   pat_cnt    out  CNT_W    vectors captured so far (saturates at PATTERNS)

module design1_bist_engine #(
    parameter int unsigned      VEC_W      = 14,
    parameter int unsigned      RSP_W      = 8,
    parameter int unsigned      PATTERNS   = 256,
    parameter logic [VEC_W-1:0] LFSR_SEED  = 14'h0001,
    parameter logic [VEC_W-1:0] LFSR_POLY  = 14'h002B,
    parameter logic [RSP_W-1:0] MISR_POLY  = 8'h1D,
    parameter logic [RSP_W-1:0] GOLDEN_SIG = 8'h00
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic [VEC_W-1:0]                  stim,
    input  logic [RSP_W-1:0]                  rsp,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [RSP_W-1:0]                  signature,
    output logic [$clog2(PATTERNS+1)-1:0]     pat_cnt
);

    localparam int unsigned CNT_W = $clog2(PATTERNS + 1);

    // An all-zero seed would lock the LFSR; fall back to 1.
    localparam logic [VEC_W-1:0] SEED =
        (LFSR_SEED == '0) ? {{(VEC_W-1){1'b0}}, 1'b1} : LFSR_SEED;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(PATTERNS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
`ifdef BIST_SETTLE_EN
        DONE   = 2'd2,
        SETTLE = 2'd3
`else
        DONE   = 2'd2
`endif
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [VEC_W-1:0]  lfsr;
    logic [VEC_W-1:0]  lfsr_next;
    logic [RSP_W-1:0]  misr;
    logic [RSP_W-1:0]  misr_next;
    logic [CNT_W-1:0]  cnt;

    logic              load;
    logic              capture;
    logic              finish;

    assign lfsr_next = {lfsr[VEC_W-2:0], 1'b0} ^ (lfsr[VEC_W-1] ? LFSR_POLY : '0);
    assign misr_next = ({misr[RSP_W-2:0], 1'b0} ^ (misr[RSP_W-1] ? MISR_POLY : '0)) ^ rsp;

    // Next-state and control strobes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
`ifdef BIST_SETTLE_EN
                // Drive-only cycle: let the netlist settle before capture.
                state_next = SETTLE;
`else
                capture = 1'b1;
                if (cnt == LAST_CNT) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
`endif
            end
`ifdef BIST_SETTLE_EN
            SETTLE: begin
                capture = 1'b1;
                if (cnt == LAST_CNT) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= SEED;
            misr      <= '0;
            cnt       <= '0;
            pass      <= 1'b0;
            signature <= '0;
        end else if (load) begin
            // signature is deliberately left alone until the new run completes
            lfsr <= SEED;
            misr <= '0;
            cnt  <= '0;
            pass <= 1'b0;
        end else if (capture) begin
            lfsr <= lfsr_next;
            misr <= misr_next;
            if (cnt != MAX_CNT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (finish) begin
                signature <= misr_next;
                pass      <= (misr_next == GOLDEN_SIG);
            end
        end
    end

    assign stim    = lfsr;
    assign pat_cnt = cnt;
    assign done    = (state == DONE);
`ifdef BIST_SETTLE_EN
    assign busy    = (state == RUN) || (state == SETTLE);
`else
    assign busy    = (state == RUN);
`endif

endmodule

// File: tb/tb_design1_bist_engine.sv
// tb_design1_bist_engine
//   Self-checking bench for design1_bist_engine. Three instances share clk/rst:
//     dut_a  PATTERNS=4, rsp tied to 0      (LFSR order, back-to-back)
//     dut_b  PATTERNS=2, rsp tied to 8'hFF  (MISR arithmetic)
//     dut_c  default params, rsp from a stand-in netlist with optional stuck-at
//   Honors BIST_SETTLE_EN (two cycles per pattern).

module tb_design1_bist_engine;

`ifdef BIST_SETTLE_EN
    localparam int CPP = 2;
`else
    localparam int CPP = 1;
`endif

    // Stand-in combinational netlist, 14 in / 8 out.
    function automatic logic [7:0] netlist_fn(input logic [13:0] v);
        return v[7:0] ^ {v[13:8], v[1:0]} ^ (v[13:6] & {v[3:0], v[11:8]});
    endfunction

    // Reference signature: seed 1, x^14+x^5+x^3+x+1 LFSR, x^8+x^4+x^3+x^2+1 MISR.
    function automatic logic [7:0] model_sig(input int n, input logic [7:0] stuck);
        logic [13:0] l;
        logic [7:0]  m;
        logic [7:0]  r;
        l = 14'h0001;
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            r = (l[7:0] ^ {l[13:8], l[1:0]} ^ (l[13:6] & {l[3:0], l[11:8]})) | stuck;
            m = ({m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00)) ^ r;
            l = {l[12:0], 1'b0} ^ (l[13] ? 14'h002B : 14'h0000);
        end
        return m;
    endfunction

    localparam logic [7:0] GOLD = model_sig(256, 8'h00);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b, start_c;
    logic [13:0] stim_a, stim_b, stim_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        pass_a, pass_b, pass_c;
    logic [7:0]  sig_a, sig_b, sig_c;
    logic [2:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic [8:0]  cnt_c;
    logic [7:0]  fault_mask;
    logic [7:0]  rsp_c;

    assign rsp_c = netlist_fn(stim_c) | fault_mask;

    design1_bist_engine #(.PATTERNS(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .rsp(8'h00),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pat_cnt(cnt_a)
    );

    design1_bist_engine #(.PATTERNS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .rsp(8'hFF),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pat_cnt(cnt_b)
    );

    design1_bist_engine #(.GOLDEN_SIG(GOLD)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .stim(stim_c), .rsp(rsp_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .pat_cnt(cnt_c)
    );

    // Observation mux over the three instances.
    int          sel;
    logic [13:0] m_stim;
    logic        m_busy, m_done, m_pass;
    logic [7:0]  m_sig;
    logic [8:0]  m_cnt;

    always_comb begin
        case (sel)
            0: begin
                m_stim = stim_a; m_busy = busy_a; m_done = done_a;
                m_pass = pass_a; m_sig = sig_a; m_cnt = 9'(cnt_a);
            end
            1: begin
                m_stim = stim_b; m_busy = busy_b; m_done = done_b;
                m_pass = pass_b; m_sig = sig_b; m_cnt = 9'(cnt_b);
            end
            default: begin
                m_stim = stim_c; m_busy = busy_c; m_done = done_c;
                m_pass = pass_c; m_sig = sig_c; m_cnt = cnt_c;
            end
        endcase
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] exp_stim_q[$];
    logic [7:0]  exp_sig_q[$];
    logic [13:0] obs_stim_q[$];
    logic [8:0]  obs_cnt_q[$];

    task automatic set_start(input int s, input logic v);
        case (s)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Pulses start on instance s and records stim/pat_cnt on every busy cycle
    // until done rises or the budget expires. Optional re-pulse of start at
    // busy cycle repulse_at.
    task automatic drive_run(input int s, input int budget, input int repulse_at,
                             output int busy_cycles, output bit timeout);
        sel = s;
        obs_stim_q.delete();
        obs_cnt_q.delete();
        busy_cycles = 0;
        timeout     = 1'b1;
        set_start(s, 1'b1);
        @(posedge clk); #1;
        set_start(s, 1'b0);
        for (int c = 1; c <= budget; c++) begin
            if (m_done) begin
                timeout = 1'b0;
                break;
            end
            if (m_busy) begin
                busy_cycles++;
                obs_stim_q.push_back(m_stim);
                obs_cnt_q.push_back(m_cnt);
            end
            set_start(s, (c == repulse_at));
            @(posedge clk); #1;
        end
        set_start(s, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (stim_c !== 14'h0001) begin n_err++; $display("FAIL reset_stim: got %h expected %h", stim_c, 14'h0001); end
        n_cmp++; if (busy_c !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_c); end
        n_cmp++; if (done_c !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b expected 0", done_c); end
        n_cmp++; if (pass_c !== 1'b0)     begin n_err++; $display("FAIL reset_pass: got %b expected 0", pass_c); end
        n_cmp++; if (sig_c !== 8'h00)     begin n_err++; $display("FAIL reset_sig: got %h expected 00", sig_c); end
        n_cmp++; if (cnt_c !== 9'd0)      begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", cnt_c); end
        n_cmp++; if (stim_a !== 14'h0001) begin n_err++; $display("FAIL reset_stim_a: got %h expected 0001", stim_a); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lfsr_order();
        int bc;
        bit to;
        logic [13:0] o, e;
        logic [13:0] seq [4];
        seq[0] = 14'h0001; seq[1] = 14'h0002; seq[2] = 14'h0004; seq[3] = 14'h0008;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < CPP; k++) exp_stim_q.push_back(seq[p]);
        exp_sig_q.push_back(8'h00);
        drive_run(0, 50, 0, bc, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL lfsr_timeout: done not seen within 50 cycles"); end
        n_cmp++; if (bc != 4 * CPP) begin n_err++; $display("FAIL lfsr_busy_len: got %0d expected %0d", bc, 4 * CPP); end
        n_cmp++; if (obs_stim_q.size() != exp_stim_q.size()) begin
            n_err++; $display("FAIL lfsr_seq_len: got %0d expected %0d", obs_stim_q.size(), exp_stim_q.size());
        end
        while (obs_stim_q.size() > 0 && exp_stim_q.size() > 0) begin
            o = obs_stim_q.pop_front();
            e = exp_stim_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL lfsr_stim: got %h expected %h", o, e); end
        end
        exp_stim_q.delete();
        for (int k = 0; k < obs_cnt_q.size(); k++) begin
            n_cmp++; if (obs_cnt_q[k] !== 9'(k / CPP)) begin
                n_err++; $display("FAIL lfsr_pat_cnt[%0d]: got %0d expected %0d", k, obs_cnt_q[k], k / CPP);
            end
        end
        e = 14'(exp_sig_q.pop_front());
        n_cmp++; if (m_done !== 1'b1) begin n_err++; $display("FAIL lfsr_done: got %b expected 1", m_done); end
        n_cmp++; if (m_sig !== e[7:0]) begin n_err++; $display("FAIL lfsr_sig: got %h expected %h", m_sig, e[7:0]); end
        n_cmp++; if (m_pass !== 1'b1) begin n_err++; $display("FAIL lfsr_pass: got %b expected 1", m_pass); end
        n_cmp++; if (m_cnt !== 9'd4) begin n_err++; $display("FAIL lfsr_final_cnt: got %0d expected 4", m_cnt); end
        // done must hold and pat_cnt must not move once the run is over
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (m_done !== 1'b1) begin n_err++; $display("FAIL lfsr_done_hold: got %b expected 1", m_done); end
        n_cmp++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL lfsr_busy_after: got %b expected 0", m_busy); end
        n_cmp++; if (m_cnt !== 9'd4) begin n_err++; $display("FAIL lfsr_cnt_sat: got %0d expected 4", m_cnt); end
    endtask

    task automatic test_misr_math();
        int bc;
        bit to;
        bit fin;
        logic [7:0] e;
        exp_sig_q.push_back(8'h1C);
        drive_run(1, 50, 0, bc, to);
        e = exp_sig_q.pop_front();
        n_cmp++; if (to) begin n_err++; $display("FAIL misr_timeout: done not seen within 50 cycles"); end
        n_cmp++; if (bc != 2 * CPP) begin n_err++; $display("FAIL misr_busy_len: got %0d expected %0d", bc, 2 * CPP); end
        n_cmp++; if (m_sig !== e) begin n_err++; $display("FAIL misr_sig: got %h expected %h", m_sig, e); end
        n_cmp++; if (m_pass !== 1'b0) begin n_err++; $display("FAIL misr_pass: got %b expected 0", m_pass); end
        // restart: old signature stays visible while the new run is in flight
        exp_sig_q.push_back(8'h1C);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n_cmp++; if (m_busy !== 1'b1) begin n_err++; $display("FAIL misr_restart_busy: got %b expected 1", m_busy); end
        n_cmp++; if (m_done !== 1'b0) begin n_err++; $display("FAIL misr_restart_done: got %b expected 0", m_done); end
        n_cmp++; if (m_sig !== 8'h1C) begin n_err++; $display("FAIL misr_sig_hold: got %h expected 1c", m_sig); end
        fin = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m_done) begin fin = 1'b1; break; end
            @(posedge clk); #1;
        end
        e = exp_sig_q.pop_front();
        n_cmp++; if (!fin) begin n_err++; $display("FAIL misr_restart_timeout: done not seen within 20 cycles"); end
        n_cmp++; if (m_sig !== e) begin n_err++; $display("FAIL misr_sig_rerun: got %h expected %h", m_sig, e); end
    endtask

    task automatic test_netlist();
        int bc;
        bit to;
        logic [13:0] l, o, e;
        logic [7:0]  es;
        logic        ep;
        fault_mask = 8'h00;
        l = 14'h0001;
        for (int p = 0; p < 256; p++) begin
            for (int k = 0; k < CPP; k++) exp_stim_q.push_back(l);
            l = {l[12:0], 1'b0} ^ (l[13] ? 14'h002B : 14'h0000);
        end
        exp_sig_q.push_back(model_sig(256, 8'h00));
        drive_run(2, 1200, 0, bc, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL net_timeout: done not seen within 1200 cycles"); end
        n_cmp++; if (bc != 256 * CPP) begin n_err++; $display("FAIL net_busy_len: got %0d expected %0d", bc, 256 * CPP); end
        n_cmp++; if (obs_stim_q.size() != exp_stim_q.size()) begin
            n_err++; $display("FAIL net_seq_len: got %0d expected %0d", obs_stim_q.size(), exp_stim_q.size());
        end
        while (obs_stim_q.size() > 0 && exp_stim_q.size() > 0) begin
            o = obs_stim_q.pop_front();
            e = exp_stim_q.pop_front();
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL net_stim: got %h expected %h", o, e); end
        end
        exp_stim_q.delete();
        es = exp_sig_q.pop_front();
        n_cmp++; if (m_sig !== es) begin n_err++; $display("FAIL net_sig: got %h expected %h", m_sig, es); end
        n_cmp++; if (m_pass !== 1'b1) begin n_err++; $display("FAIL net_pass: got %b expected 1", m_pass); end
        n_cmp++; if (m_cnt !== 9'd256) begin n_err++; $display("FAIL net_cnt: got %0d expected 256", m_cnt); end

        // stuck-at-1 on netlist output bit 4
        fault_mask = 8'h10;
        exp_sig_q.push_back(model_sig(256, 8'h10));
        drive_run(2, 1200, 0, bc, to);
        es = exp_sig_q.pop_front();
        ep = (es == GOLD);
        n_cmp++; if (to) begin n_err++; $display("FAIL stuck_timeout: done not seen within 1200 cycles"); end
        n_cmp++; if (m_sig !== es) begin n_err++; $display("FAIL stuck_sig: got %h expected %h", m_sig, es); end
        n_cmp++; if (m_pass !== ep) begin n_err++; $display("FAIL stuck_pass: got %b expected %b", m_pass, ep); end
        fault_mask = 8'h00;
    endtask

    task automatic test_start_ignored();
        int bc;
        bit to;
        logic [7:0] es;
        exp_sig_q.push_back(model_sig(256, 8'h00));
        drive_run(2, 1200, 10, bc, to);
        es = exp_sig_q.pop_front();
        n_cmp++; if (to) begin n_err++; $display("FAIL ign_timeout: done not seen within 1200 cycles"); end
        n_cmp++; if (bc != 256 * CPP) begin n_err++; $display("FAIL ign_busy_len: got %0d expected %0d", bc, 256 * CPP); end
        n_cmp++; if (m_sig !== es) begin n_err++; $display("FAIL ign_sig: got %h expected %h", m_sig, es); end
        n_cmp++; if (m_pass !== 1'b1) begin n_err++; $display("FAIL ign_pass: got %b expected 1", m_pass); end
    endtask

    task automatic test_rst_midrun();
        int bc;
        bit to;
        logic [7:0] es;
        sel = 2;
        start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        n_cmp++; if (busy_c !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b expected 1", busy_c); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (stim_c !== 14'h0001) begin n_err++; $display("FAIL rst_mid_stim: got %h expected 0001", stim_c); end
        n_cmp++; if (busy_c !== 1'b0)     begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy_c); end
        n_cmp++; if (done_c !== 1'b0)     begin n_err++; $display("FAIL rst_mid_done: got %b expected 0", done_c); end
        n_cmp++; if (pass_c !== 1'b0)     begin n_err++; $display("FAIL rst_mid_pass: got %b expected 0", pass_c); end
        n_cmp++; if (sig_c !== 8'h00)     begin n_err++; $display("FAIL rst_mid_sig: got %h expected 00", sig_c); end
        n_cmp++; if (cnt_c !== 9'd0)      begin n_err++; $display("FAIL rst_mid_cnt: got %0d expected 0", cnt_c); end
        // still idle a few cycles later: reset aborted the run for good
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy_c !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy: got %b expected 0", busy_c); end
        exp_sig_q.push_back(model_sig(256, 8'h00));
        drive_run(2, 1200, 0, bc, to);
        es = exp_sig_q.pop_front();
        n_cmp++; if (to) begin n_err++; $display("FAIL rst_rerun_timeout: done not seen within 1200 cycles"); end
        n_cmp++; if (bc != 256 * CPP) begin n_err++; $display("FAIL rst_rerun_len: got %0d expected %0d", bc, 256 * CPP); end
        n_cmp++; if (m_sig !== es) begin n_err++; $display("FAIL rst_rerun_sig: got %h expected %h", m_sig, es); end
    endtask

    task automatic test_back_to_back();
        int  done_cycles;
        bit  seen;
        bit  fin;
        sel = 0;
        done_cycles = 0;
        seen = 1'b0;
        start_a = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (m_done) begin
                done_cycles++;
            end else if (done_cycles > 0) begin
                n_cmp++; if (m_busy !== 1'b1)      begin n_err++; $display("FAIL b2b_busy: got %b expected 1", m_busy); end
                n_cmp++; if (m_stim !== 14'h0001)  begin n_err++; $display("FAIL b2b_stim: got %h expected 0001", m_stim); end
                n_cmp++; if (m_pass !== 1'b0)      begin n_err++; $display("FAIL b2b_pass_clr: got %b expected 0", m_pass); end
                n_cmp++; if (m_cnt !== 9'd0)       begin n_err++; $display("FAIL b2b_cnt: got %0d expected 0", m_cnt); end
                seen = 1'b1;
                break;
            end
        end
        start_a = 1'b0;
        n_cmp++; if (!seen) begin n_err++; $display("FAIL b2b_timeout: restart not seen within 40 cycles"); end
        n_cmp++; if (done_cycles != 1) begin n_err++; $display("FAIL b2b_done_width: got %0d expected 1", done_cycles); end
        fin = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (m_done) begin fin = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_cmp++; if (!fin) begin n_err++; $display("FAIL b2b_finish_timeout: done not seen within 40 cycles"); end
        n_cmp++; if (m_pass !== 1'b1) begin n_err++; $display("FAIL b2b_final_pass: got %b expected 1", m_pass); end
        n_cmp++; if (m_sig !== 8'h00) begin n_err++; $display("FAIL b2b_final_sig: got %h expected 00", m_sig); end
    endtask

    initial begin
        rst        = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        start_c    = 1'b0;
        fault_mask = 8'h00;
        sel        = 2;
        test_reset();
        test_lfsr_order();
        test_misr_math();
        test_netlist();
        test_start_ignored();
        test_rst_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
